div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_pkg.sv | 31 +++
 rtl/div_datapath.sv | 86 ++++++++
 rtl/div_sequencer.sv | 119 +++++++++++
 tb/tb_div_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared control-path types for the divide unit: the divide opcode and the
// compute-result source select that routes the divider output into ComputeResult_C.
`ifndef XLEN
`define XLEN 32
`endif

package HighLevelControl;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } divOp;

   typedef enum logic [1:0] {
      AluResult   = 2'd0,
      ShiftResult = 2'd1,
      MulResult   = 2'd2,
      DivResult   = 2'd3
   } computeSrc;

   function automatic logic is_signed_op(input divOp op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_rem_op(input divOp op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract divider on operand magnitudes; result_o is the
// sign-corrected quotient or remainder after the iteration performed this cycle.
`ifndef XLEN
`define XLEN 32
`endif

module div_datapath
   import HighLevelControl::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  divOp            op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;
   logic [XLEN-1:0] rem_step, quo_step;
   logic [XLEN:0]   partial, diff;
   logic            neg_a, neg_b;

   always_comb begin
      partial = {rem_q, quo_q[XLEN-1]};
      diff    = partial - {1'b0, dvsr_q};
      // Bit XLEN of the difference is set exactly when the trial subtract underflows.
      if (!diff[XLEN]) begin
         rem_step = diff[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_step = partial[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b0};
      end
      if (is_rem_q) begin
         result_o = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
      end else begin
         result_o = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
      end
   end

   always_comb begin
      neg_a     = is_signed_op(op_i) && dividend_i[XLEN-1];
      neg_b     = is_signed_op(op_i) && divisor_i[XLEN-1];
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      if (load) begin
         rem_d     = '0;
         quo_d     = neg_a ? (~dividend_i + 1'b1) : dividend_i;
         dvsr_d    = neg_b ? (~divisor_i + 1'b1) : divisor_i;
         neg_quo_d = neg_a ^ neg_b;
         neg_rem_d = neg_a;
         is_rem_d  = is_rem_op(op_i);
      end else if (step) begin
         rem_d = rem_step;
         quo_d = quo_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// C-stage divide sequencer: FSM, iteration counter, divide-by-zero / signed
// overflow fast path and pipeline stall generation around div_datapath.
`ifndef XLEN
`define XLEN 32
`endif

module div_sequencer
   import HighLevelControl::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Start_C,
   input  divOp            DivOp_C,
   input  logic [XLEN-1:0] OperandA_C,
   input  logic [XLEN-1:0] OperandB_C,
   input  logic            Advance_C,
   input  logic            Flush_C,
   output logic            Stall_C,
   output logic [XLEN-1:0] Result_C,
   output logic            ResultValid_C
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] fast_result, dp_result;
   logic            load, step, div_zero, overflow;

   always_comb begin
      div_zero = (OperandB_C == '0);
      overflow = is_signed_op(DivOp_C) && (OperandB_C == '1) &&
                 (OperandA_C == {1'b1, {(XLEN-1){1'b0}}});
      if (div_zero) begin
         fast_result = is_rem_op(DivOp_C) ? OperandA_C : '1;
      end else begin
         fast_result = is_rem_op(DivOp_C) ? '0 : OperandA_C;
      end
   end

   // Reset and flush both suppress stall/valid in the cycle they are seen.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      result_d      = result_q;
      load          = 1'b0;
      step          = 1'b0;
      Stall_C       = 1'b0;
      ResultValid_C = 1'b0;
      if (reset) begin
         state_d = IDLE;
      end else if (Flush_C) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start_C) begin
                  Stall_C = 1'b1;
                  load    = 1'b1;
                  if (div_zero || overflow) begin
                     result_d = fast_result;
                     state_d  = DONE;
                  end else begin
                     count_d = CNT_INIT;
                     state_d = BUSY;
                  end
               end
            end
            BUSY: begin
               Stall_C = 1'b1;
               step    = 1'b1;
               if (count_q == '0) begin
                  result_d = dp_result;
                  state_d  = DONE;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
            DONE: begin
               ResultValid_C = 1'b1;
               if (Advance_C) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         result_q <= result_d;
      end
   end

   assign Result_C = result_q;

   div_datapath #(.XLEN(XLEN)) u_datapath (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .op_i       (DivOp_C),
      .dividend_i (OperandA_C),
      .divisor_i  (OperandB_C),
      .result_o   (dp_result)
   );

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer at XLEN=32: latency, signed
// fix-up, fast paths, flush, reset abandon and DONE hold / back-to-back issue.
module tb_div_sequencer;
   import HighLevelControl::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start_C;
   divOp        DivOp_C;
   logic [31:0] OperandA_C;
   logic [31:0] OperandB_C;
   logic        Advance_C;
   logic        Flush_C;
   logic        Stall_C;
   logic [31:0] Result_C;
   logic        ResultValid_C;

   int checks = 0;
   int errors = 0;

   div_sequencer #(.XLEN(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .Start_C       (Start_C),
      .DivOp_C       (DivOp_C),
      .OperandA_C    (OperandA_C),
      .OperandB_C    (OperandB_C),
      .Advance_C     (Advance_C),
      .Flush_C       (Flush_C),
      .Stall_C       (Stall_C),
      .Result_C      (Result_C),
      .ResultValid_C (ResultValid_C)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input divOp op, input logic [31:0] a, input logic [31:0] b);
      Start_C    = 1'b1;
      DivOp_C    = op;
      OperandA_C = a;
      OperandB_C = b;
      Advance_C  = 1'b0;
      Flush_C    = 1'b0;
   endtask

   // Called on the negedge where Start was just applied; counts stalled cycles.
   task automatic waitResult(input string tag, input int expStall, input logic [31:0] expRes);
      int stallCycles = 0;
      #1;
      while (Stall_C === 1'b1 && stallCycles < 200) begin
         stallCycles++;
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_stall"}, 64'(stallCycles), 64'(expStall));
      checkOutput({tag, "_valid"}, 64'(ResultValid_C), 64'd1);
      checkOutput({tag, "_result"}, 64'(Result_C), 64'(expRes));
   endtask

   task automatic runDivide(input string tag, input divOp op, input logic [31:0] a,
                            input logic [31:0] b, input int expStall, input logic [31:0] expRes);
      @(negedge clk);
      applyStimulus(op, a, b);
      waitResult(tag, expStall, expRes);
   endtask

   task automatic retire(input string tag);
      Advance_C = 1'b1;
      @(negedge clk);
      Advance_C = 1'b0;
      Start_C   = 1'b0;
      #1;
      checkOutput({tag, "_idle_stall"}, 64'(Stall_C), 64'd0);
      checkOutput({tag, "_idle_valid"}, 64'(ResultValid_C), 64'd0);
   endtask

   initial begin
      reset      = 1'b1;
      Start_C    = 1'b1;
      Flush_C    = 1'b1;
      DivOp_C    = DIVU;
      OperandA_C = 32'd100;
      OperandB_C = 32'd7;
      Advance_C  = 1'b0;

      // Reset outranks Start and Flush
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_stall", 64'(Stall_C), 64'd0);
      checkOutput("reset_valid", 64'(ResultValid_C), 64'd0);
      checkOutput("reset_result", 64'(Result_C), 64'd0);
      @(negedge clk);
      reset   = 1'b0;
      Start_C = 1'b0;
      Flush_C = 1'b0;
      #1;
      checkOutput("post_reset_stall", 64'(Stall_C), 64'd0);

      runDivide("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd14);
      retire("divu_100_7");
      runDivide("remu_100_7", REMU, 32'd100, 32'd7, 33, 32'd2);
      retire("remu_100_7");
      runDivide("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
      retire("div_m7_2");
      runDivide("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
      retire("rem_m7_2");
      runDivide("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
      retire("div_7_m2");
      runDivide("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
      retire("rem_7_m2");
      runDivide("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
      retire("div_ovf");
      runDivide("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
      retire("rem_ovf");
      runDivide("divu_no_ovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
      retire("divu_no_ovf");
      runDivide("div_by0", DIV, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF);
      retire("div_by0");

      // Flush on the 10th BUSY cycle; earlier result must stay on Result_C
      @(negedge clk);
      applyStimulus(DIVU, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) @(negedge clk);
      Flush_C = 1'b1;
      Start_C = 1'b0;
      #1;
      checkOutput("flush_stall", 64'(Stall_C), 64'd0);
      checkOutput("flush_valid", 64'(ResultValid_C), 64'd0);
      @(negedge clk);
      Flush_C = 1'b0;
      #1;
      checkOutput("after_flush_stall", 64'(Stall_C), 64'd0);
      checkOutput("after_flush_valid", 64'(ResultValid_C), 64'd0);
      checkOutput("after_flush_hold", 64'(Result_C), 64'h0000_0000_FFFF_FFFF);
      runDivide("divu_9_3", DIVU, 32'd9, 32'd3, 33, 32'd3);
      retire("divu_9_3");

      runDivide("rem_by0", REM, 32'h1234_5678, 32'd0, 1, 32'h1234_5678);
      retire("rem_by0");

      // DONE held with Advance low, then back-to-back issue
      runDivide("divu_50_5", DIVU, 32'd50, 32'd5, 33, 32'd10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checkOutput("hold_valid", 64'(ResultValid_C), 64'd1);
         checkOutput("hold_result", 64'(Result_C), 64'd10);
         checkOutput("hold_stall", 64'(Stall_C), 64'd0);
      end
      Advance_C = 1'b1;
      @(negedge clk);
      applyStimulus(DIVU, 32'd81, 32'd9);
      waitResult("b2b_81_9", 33, 32'd9);
      retire("b2b_81_9");

      // Reset mid-BUSY abandons the operation
      @(negedge clk);
      applyStimulus(DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 5; i++) @(negedge clk);
      reset   = 1'b1;
      Start_C = 1'b0;
      #1;
      checkOutput("midreset_stall", 64'(Stall_C), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int validSeen = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ResultValid_C !== 1'b0 || Stall_C !== 1'b0) validSeen++;
         end
         checkOutput("midreset_no_result", 64'(validSeen), 64'd0);
      end
      checkOutput("midreset_result_cleared", 64'(Result_C), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
